// File: rtl/ps2_pkg.sv
// Shared constants and frame-FSM encoding for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Odd parity holds when the data byte and the parity bit together carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Decoded keyboard event bus from the receiver to its consumer.
interface ps2_kbd_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       released;
    logic       extended;
    logic       err;

    modport master (output data, valid, released, extended, err);
    modport slave  (input  data, valid, released, extended, err);
endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchroniser, consecutive-sample glitch filter and falling-edge detector.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic fall
);

    logic [1:0] sync_reg;
    logic [7:0] cnt_reg, cnt_next;
    logic       level_reg, level_next;
    logic       level_prev_reg;

    // Counter tracks a run of samples disagreeing with the filtered level; any agreement restarts it.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (sync_reg[1] != level_reg) begin
            if (cnt_reg == 8'(FILTER_LEN - 1))
                level_next = sync_reg[1];
            else
                cnt_next = cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= 2'b11;
            cnt_reg        <= '0;
            level_reg      <= 1'b1;
            level_prev_reg <= 1'b1;
        end else begin
            sync_reg       <= {sync_reg[0], pin};
            cnt_reg        <= cnt_next;
            level_reg      <= level_next;
            level_prev_reg <= level_reg;
        end
    end

    assign fall = level_prev_reg & ~level_reg;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame deserialiser plus F0/E0 prefix folding into release/extended flags.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_kbd_rx_if.master    bus
);

    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              fall;
    logic [1:0]        data_sync_reg;
    logic              data_bit;

    ps2_state_t        state_reg, state_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic              parity_reg, parity_next;
    logic [TOUT_W-1:0] tout_cnt_reg, tout_cnt_next;
    logic              accept_next, frame_err_next, tout_hit_next;

    // Pipeline stage between frame acceptance and the registered outputs.
    logic              accept_reg, bad_reg, tout_hit_reg;
    logic [7:0]        byte_reg;

    logic              break_pending_reg, break_pending_next;
    logic              ext_pending_reg, ext_pending_next;
    logic [7:0]        data_reg, data_next;
    logic              released_reg, released_next;
    logic              extended_reg, extended_next;
    logic              valid_reg, valid_next;
    logic              err_reg, err_next;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2_clk),
        .fall (fall)
    );

    assign data_bit = data_sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        parity_next    = parity_reg;
        tout_cnt_next  = tout_cnt_reg;
        accept_next    = 1'b0;
        frame_err_next = 1'b0;
        tout_hit_next  = 1'b0;
        if (state_reg != IDLE)
            tout_cnt_next = tout_cnt_reg + TOUT_W'(1);
        if (fall) begin
            tout_cnt_next = '0;
            case (state_reg)
                IDLE: begin
                    // A high start bit is line noise, not an error.
                    if (!data_bit) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {data_bit, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = PARITY;
                end
                PARITY: begin
                    parity_next = data_bit;
                    state_next  = STOP;
                end
                STOP: begin
                    if (data_bit && odd_parity_ok(shift_reg, parity_reg))
                        accept_next = 1'b1;
                    else
                        frame_err_next = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && tout_cnt_reg == TOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state_next     = IDLE;
            tout_cnt_next  = '0;
            frame_err_next = 1'b1;
            tout_hit_next  = 1'b1;
        end
    end

    // Code layer: prefixes only arm flags; any other byte produces an event and consumes them.
    always_comb begin
        data_next          = data_reg;
        released_next      = released_reg;
        extended_next      = extended_reg;
        valid_next         = 1'b0;
        err_next           = bad_reg;
        break_pending_next = break_pending_reg;
        ext_pending_next   = ext_pending_reg;
        if (tout_hit_reg) begin
            break_pending_next = 1'b0;
            ext_pending_next   = 1'b0;
        end
        if (accept_reg) begin
            if (byte_reg == PS2_BREAK) begin
                break_pending_next = 1'b1;
            end else if (byte_reg == PS2_EXT) begin
                ext_pending_next = 1'b1;
            end else begin
                data_next          = byte_reg;
                released_next      = break_pending_reg;
                extended_next      = ext_pending_reg;
                valid_next         = 1'b1;
                break_pending_next = 1'b0;
                ext_pending_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_sync_reg     <= 2'b11;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            parity_reg        <= 1'b0;
            tout_cnt_reg      <= '0;
            accept_reg        <= 1'b0;
            bad_reg           <= 1'b0;
            tout_hit_reg      <= 1'b0;
            byte_reg          <= '0;
            break_pending_reg <= 1'b0;
            ext_pending_reg   <= 1'b0;
            data_reg          <= '0;
            released_reg      <= 1'b0;
            extended_reg      <= 1'b0;
            valid_reg         <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            data_sync_reg     <= {data_sync_reg[0], ps2_data};
            bit_cnt_reg       <= bit_cnt_next;
            shift_reg         <= shift_next;
            parity_reg        <= parity_next;
            tout_cnt_reg      <= tout_cnt_next;
            accept_reg        <= accept_next;
            bad_reg           <= frame_err_next;
            tout_hit_reg      <= tout_hit_next;
            byte_reg          <= accept_next ? shift_reg : byte_reg;
            break_pending_reg <= break_pending_next;
            ext_pending_reg   <= ext_pending_next;
            data_reg          <= data_next;
            released_reg      <= released_next;
            extended_reg      <= extended_next;
            valid_reg         <= valid_next;
            err_reg           <= err_next;
        end
    end

    assign bus.data     = data_reg;
    assign bus.valid    = valid_reg;
    assign bus.released = released_reg;
    assign bus.extended = extended_reg;
    assign bus.err      = err_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: drives PS/2 frames, queues expected events, compares on output.
module tb_ps2_kbd_rx;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    ps2_kbd_rx_if bus();

    ps2_kbd_rx #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;

    ev_t sb_q[$];
    int  err_cnt = 0;
    int  chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_code(input logic [7:0] code, input logic rel, input logic ext);
        ev_t e;
        e.is_err = 1'b0;
        e.code   = code;
        e.rel    = rel;
        e.ext    = ext;
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e = '0;
        e.is_err = 1'b1;
        sb_q.push_back(e);
    endtask

    // One PS/2 bit: 50-cycle high phase (data changes 25 cycles before the fall), 50-cycle low phase.
    task automatic bit_cycle(input logic v, input bit glitch);
        repeat (10) @(posedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (2) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (13) @(posedge clk);
        end else begin
            repeat (15) @(posedge clk);
        end
        ps2_data = v;
        repeat (25) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (50) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends frame bits [first..last] (0 = start, 1..8 = data, 9 = parity, 10 = stop).
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int first, input int last,
                             input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = first; i <= last; i++)
            bit_cycle(bits[i], glitch);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        send_bits(b, bad_par, 0, 10, glitch);
        repeat (100) @(posedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, sb_q.size(), 0);
        repeat (20) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.valid || bus.err)) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_evt", {22'd0, bus.err, bus.valid, bus.data}, 32'd0);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                $display("event: valid=%0b err=%0b data=%02h rel=%0b ext=%0b",
                         bus.valid, bus.err, bus.data, bus.released, bus.extended);
                check_eq("evt_kind", {bus.valid, bus.err}, e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    check_eq("evt_data", bus.data, e.code);
                    check_eq("evt_released", bus.released, e.rel);
                    check_eq("evt_extended", bus.extended, e.ext);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_data", bus.data, 0);
        check_eq("rst_valid", bus.valid, 0);
        check_eq("rst_released", bus.released, 0);
        check_eq("rst_extended", bus.extended, 0);
        check_eq("rst_err", bus.err, 0);

        push_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("drain_make");

        push_code(8'h1C, 1'b1, 1'b0);
        push_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("drain_break");

        push_code(8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        drain("drain_ext_break");

        push_err();
        send_frame(8'h1C, 1'b1, 1'b0);
        drain("drain_bad_parity");
        check_eq("hold_data", bus.data, 8'h75);
        check_eq("hold_released", bus.released, 1);
        check_eq("hold_extended", bus.extended, 1);
        push_code(8'h32, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
        drain("drain_after_parity");

        push_code(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        drain("drain_glitch");

        // Start plus four data bits, then the clock stops: a timeout error is due.
        push_err();
        send_bits(8'h3C, 1'b0, 0, 4, 1'b0);
        drain("drain_timeout");
        push_code(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0);
        drain("drain_after_timeout");

        send_bits(8'h1C, 1'b0, 0, 4, 1'b0);
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_data", bus.data, 0);
        check_eq("midrst_valid", bus.valid, 0);
        check_eq("midrst_released", bus.released, 0);
        check_eq("midrst_extended", bus.extended, 0);
        check_eq("midrst_err", bus.err, 0);
        // Leftover bits: D4=1 is ignored, D5=0 looks like a start; only four more falls follow, so it times out.
        push_err();
        send_bits(8'h1C, 1'b0, 5, 10, 1'b0);
        drain("drain_midrst_tail");
        push_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("drain_after_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
